// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with CPU priority and starvation guard
//
// Purpose:
//   Shares one single-ported data memory between the CPU MEM stage and an
//   external loader/debug port. The CPU wins conflicts until the external
//   port has been denied STARVE_LIM consecutive cycles, after which the
//   external port is forced through once. Read data is steered back to the
//   requester that issued the read, one cycle after the grant.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wd            CPU access request
//   cpu_stall                     CPU request not accepted this cycle
//   cpu_rvalid, cpu_rd            CPU read return
//   ext_req/we/addr/wd            external access request (held until granted)
//   ext_gnt                       external request accepted this cycle
//   ext_rvalid, ext_rd            external read return
//   mem_en/we/addr/wd, mem_rd     memory port (read data one cycle after mem_en)

module dmem_arbiter #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rd,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wd,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rd,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;   // 1 = external port owns the pending read

  logic ext_forced;
  logic gnt_cpu;
  logic gnt_ext;

  always_comb begin
    ext_forced = (wait_cnt_q >= LIM);

    // Reset masks both grants so no access leaks out while rst is high.
    gnt_cpu = !rst && cpu_req && !(ext_req && ext_forced);
    gnt_ext = !rst && ext_req && !gnt_cpu;

    mem_en   = gnt_cpu || gnt_ext;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (gnt_cpu) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end else if (gnt_ext) begin
      mem_we   = ext_we;
      mem_addr = ext_addr;
      mem_wd   = ext_wd;
    end

    ext_gnt   = gnt_ext;
    cpu_stall = !rst && cpu_req && !gnt_cpu;

    // Starve counter: cleared by a grant, saturates while denied, and
    // holds when the external port withdraws its request.
    wait_cnt_d = wait_cnt_q;
    if (gnt_ext) begin
      wait_cnt_d = '0;
    end else if (ext_req && (wait_cnt_q < LIM)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    // Return tag is rewritten every cycle, so a pending read clears itself
    // unless a new read (from either owner) is granted right behind it.
    rd_pend_d  = mem_en && !mem_we;
    rd_owner_d = gnt_ext;

    // Masking with rst drops a return that was due in the reset cycle.
    cpu_rvalid = !rst && rd_pend_q && !rd_owner_q;
    ext_rvalid = !rst && rd_pend_q && rd_owner_q;
    cpu_rd     = cpu_rvalid ? mem_rd : '0;
    ext_rd     = ext_rvalid ? mem_rd : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_LIM, default 4, range 1..15: consecutive denied external-request cycles before the external port is forced ahead of the CPU.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port cpu_req  input  1  CPU MEM stage requests a data-memory access this cycle.
REQ-005 Port cpu_we  input  1  CPU access is a write.
REQ-006 Port cpu_addr  input  32  CPU byte address.
REQ-007 Port cpu_wd  input  32  CPU write data.
REQ-008 Port cpu_stall  output  1  CPU access not accepted this cycle; the pipeline holds its MEM stage.
REQ-009 Port cpu_rvalid  output  1  cpu_rd is valid; pulses one cycle after an accepted CPU read.
REQ-010 Port cpu_rd  output  32  CPU read data.
REQ-011 Port ext_req  input  1  external (loader/debug) port requests an access; held until granted.
REQ-012 Port ext_we  input  1  external access is a write.
REQ-013 Port ext_addr  input  32  external byte address.
REQ-014 Port ext_wd  input  32  external write data.
REQ-015 Port ext_gnt  output  1  external access accepted this cycle.
REQ-016 Port ext_rvalid  output  1  ext_rd is valid; pulses one cycle after a granted external read.
REQ-017 Port ext_rd  output  32  external read data.
REQ-018 Port mem_en  output  1  memory access strobe.
REQ-019 Port mem_we  output  1  memory write enable.
REQ-020 Port mem_addr  output  32  memory address.
REQ-021 Port mem_wd  output  32  memory write data.
REQ-022 Port mem_rd  input  32  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-023 Grant decision is combinational within the cycle and uses the registered starve counter (wait_cnt, 4 bits); exactly one requester or neither is granted per cycle.
REQ-024 Granting rules: only cpu_req -> CPU; only ext_req -> EXT; both with wait_cnt < STARVE_LIM -> CPU; both with wait_cnt == STARVE_LIM -> EXT; neither -> idle, mem_en=0.
REQ-025 CPU grant drives mem_en=1 and mem_we/addr/wd from cpu_*, with cpu_stall=0 and ext_gnt=0.
REQ-026 EXT grant drives mem_en=1 and mem_we/addr/wd from ext_*, with ext_gnt=1; cpu_stall=1 if cpu_req=1.
REQ-027 cpu_stall=0 whenever cpu_req=0.
REQ-028 wait_cnt increments, saturating at STARVE_LIM, on every cycle where ext_req=1 and ext_gnt=0; it clears to 0 on any cycle with ext_gnt=1; it holds when ext_req=0.
REQ-029 Read routing uses a registered return tag (rd_pend valid bit plus owner bit) set on every granted read and cleared the next cycle unless another read is granted; back-to-back reads by different owners are supported.
REQ-030 cpu_rvalid=1 and cpu_rd=mem_rd exactly one cycle after a CPU read grant; likewise ext_rvalid/ext_rd for EXT; both rvalids are never high together.
REQ-031 Writes produce no rvalid; a write granted in cycle N does not disturb a read return due in cycle N.
REQ-032 cpu_rd and ext_rd show mem_rd when their own rvalid=1 and 0 otherwise.
REQ-033 If ext_req drops before grant, no access is issued and wait_cnt holds its value.

Reset
REQ-034 While rst=1: mem_en=0, mem_we=0, ext_gnt=0, cpu_stall=0, cpu_rvalid=0, ext_rvalid=0, wait_cnt=0, rd_pend=0, regardless of requests.
REQ-035 On the first cycle after rst falls, arbitration resumes from wait_cnt=0; a read granted in the cycle when rst rises returns no rvalid.

Verification
REQ-036 Reset, then CPU read addr 0x10 with mem_rd=0xDEADBEEF -> cpu_stall=0, mem_en=1 the same cycle; next cycle cpu_rvalid=1, cpu_rd=0xDEADBEEF.
REQ-037 ext_req write addr 0x20, data 0x5 with cpu_req=0 -> ext_gnt=1, mem_we=1, mem_addr=0x20, mem_wd=0x5 the same cycle; no ext_rvalid.
REQ-038 cpu_req and ext_req held high continuously with STARVE_LIM=4 -> CPU granted cycles 0-3, EXT granted cycle 4 with cpu_stall=1, wait_cnt back to 0, and the pattern repeats every 5 cycles.
REQ-039 EXT read in cycle N then CPU read in cycle N+1 -> ext_rvalid=1 in N+1 only, cpu_rvalid=1 in N+2 only, with data routed correctly.
REQ-040 rst asserted in the same cycle as granted reads -> no rvalid the following cycle, all outputs at reset values, wait_cnt=0.
REQ-041 ext_req pulsed for 2 cycles under CPU load, then withdrawn -> no external access, wait_cnt=2 and held until ext_req returns.
